// File: rtl/audio_pwm_out.sv
// Sample-stream sink: paces sample requests, scales each sample by BCD volume, drives an 8-bit PWM pin.
// Latency: capture on the tick edge, scaled sample lands in pending 10 edges later; duty follows on the next PWM wrap.
// Backpressure: none upstream; ticks arriving while a scale op is in flight are dropped and the op completes.
module audio_pwm_out #(
    parameter int unsigned SAMPLE_DIV = 6250
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       play,
    input  logic [7:0] sample,
    input  logic [3:0] volume1,
    input  logic [3:0] volume0,
    output logic       sample_req,
    output logic       busy,
    output logic       pwm_out
);

    localparam logic [15:0] DIV_LAST = 16'(SAMPLE_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] div_cnt_q;
    logic        tick;

    logic [7:0]  centered_q;
    logic [6:0]  vol_q;
    logic [14:0] mcand_q;
    logic [7:0]  mplier_q;
    logic        sign_q;
    logic [14:0] acc_q;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  pending_q;

    logic [7:0]  pwm_cnt_q;
    logic [7:0]  duty_q;
    logic        pwm_out_q;

    logic [3:0]  v1_clamped, v0_clamped;
    logic [6:0]  vol_now;
    logic [7:0]  gain_sum, gain;
    logic [7:0]  mag;
    logic [14:0] prod;

    assign tick = (div_cnt_q == 16'd0);

    // Non-BCD digits saturate to 9 so the volume never exceeds 99.
    assign v1_clamped = (volume1 > 4'd9) ? 4'd9 : volume1;
    assign v0_clamped = (volume0 > 4'd9) ? 4'd9 : volume0;
    assign vol_now    = 7'(v1_clamped) * 7'd10 + 7'(v0_clamped);

    // vol*(1 + 1/4 + 1/16) approximates vol*128/99, so 99 maps to unity (clamped at 128).
    assign gain_sum = {1'b0, vol_q} + {3'b000, vol_q[6:2]} + {5'b00000, vol_q[6:4]};
    assign gain     = (gain_sum > 8'd128) ? 8'd128 : gain_sum;

    // |centered|; 0x80 (-128) correctly yields 128 as an unsigned byte.
    assign mag = centered_q[7] ? (8'd0 - centered_q) : centered_q;

    // |product| <= 16384, so a 15-bit two's-complement value holds it (including -16384);
    // bits [14:7] are then exactly the floor-toward-minus-infinity divide by 128.
    assign prod = sign_q ? (15'd0 - acc_q) : acc_q;

    // Free-running sample-period divider, independent of play.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt_q <= DIV_LAST;
        end else if (tick) begin
            div_cnt_q <= DIV_LAST;
        end else begin
            div_cnt_q <= div_cnt_q - 16'd1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: one capture per tick, then a fixed 10-cycle scale sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (tick && play) state_d = LOAD;
            LOAD:    state_d = MUL;
            MUL:     if (bit_cnt_q == 3'd7) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: request only when a tick is actually accepted.
    always_comb begin
        sample_req = 1'b0;
        busy       = 1'b0;
        case (state_q)
            IDLE:     sample_req = tick & play;
            LOAD,
            MUL:      busy = 1'b1;
            default: ;
        endcase
    end

    // Scaling datapath: capture, operand load, LSB-first shift-add, signed rescale into pending.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            centered_q <= 8'h00;
            vol_q      <= 7'd0;
            mcand_q    <= 15'd0;
            mplier_q   <= 8'd0;
            sign_q     <= 1'b0;
            acc_q      <= 15'd0;
            bit_cnt_q  <= 3'd0;
            pending_q  <= 8'h80;
        end else begin
            case (state_q)
                IDLE: begin
                    if (tick) begin
                        if (play) begin
                            centered_q <= sample ^ 8'h80;
                            vol_q      <= vol_now;
                        end else begin
                            pending_q  <= 8'h80;
                        end
                    end
                end
                LOAD: begin
                    mcand_q   <= {7'd0, mag};
                    mplier_q  <= gain;
                    sign_q    <= centered_q[7];
                    acc_q     <= 15'd0;
                    bit_cnt_q <= 3'd0;
                end
                MUL: begin
                    if (mplier_q[0]) begin
                        acc_q <= acc_q + mcand_q;
                    end
                    mcand_q   <= mcand_q << 1;
                    mplier_q  <= mplier_q >> 1;
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                end
                DONE: begin
                    pending_q <= prod[14:7] + 8'd128;
                end
                default: ;
            endcase
        end
    end

    // PWM: duty only reloads at the period boundary so a period is never cut mid-way.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pwm_cnt_q <= 8'd0;
            duty_q    <= 8'h80;
            pwm_out_q <= 1'b0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 8'd1;
            if (pwm_cnt_q == 8'hFF) begin
                duty_q <= pending_q;
            end
            pwm_out_q <= (pwm_cnt_q < duty_q);
        end
    end

    assign pwm_out = pwm_out_q;

endmodule

// File: tb/tb_audio_pwm_out.sv
// Bench for audio_pwm_out: time-indexed behavioural model plus directed PWM-period measurements.
module tb_audio_pwm_out;

    localparam int D = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       play;
    logic [7:0] sample;
    logic [3:0] volume1, volume0;
    logic       sample_req, busy, pwm_out;

    int n_vec = 0;
    int n_err = 0;

    audio_pwm_out #(.SAMPLE_DIV(D)) dut (
        .clk        (clk),
        .reset      (reset),
        .play       (play),
        .sample     (sample),
        .volume1    (volume1),
        .volume0    (volume0),
        .sample_req (sample_req),
        .busy       (busy),
        .pwm_out    (pwm_out)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
        $fatal(1, "watchdog");
    end

    // Expected pending for one captured sample: floor(centered*G/128)+128.
    function automatic int exp_pend(input int s, input int v1, input int v0);
        int vol, g, p, q;
        vol = 10 * ((v1 > 9) ? 9 : v1) + ((v0 > 9) ? 9 : v0);
        g = vol + vol / 4 + vol / 16;
        if (g > 128) g = 128;
        p = (s - 128) * g;
        q = (p >= 0) ? (p / 128) : -((-p + 127) / 128);
        return q + 128;
    endfunction

    // Model, indexed by m_k = rising edges since reset release.
    // Ticks fall in cycles with m_k % D == D-1; a capture at edge c lands in pending at edge c+10.
    int m_k = 0;
    int m_cap = -100;
    int m_free = 0;
    int m_pending = 128;
    int m_duty = 128;
    bit m_pwm = 1'b0;
    int sq_edge[$];
    int sq_val[$];
    int me;
    bit mtick, midle;
    int mprev;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_k = 0; m_cap = -100; m_free = 0;
            m_pending = 128; m_duty = 128; m_pwm = 1'b0;
            sq_edge.delete(); sq_val.delete();
        end else begin
            me    = m_k + 1;
            mtick = (m_k % D == D - 1);
            midle = (m_k >= m_free);
            mprev = m_pending;
            m_pwm = ((m_k % 256) < m_duty);
            if (me % 256 == 0) m_duty = mprev;
            if (mtick && midle) begin
                if (play) begin
                    m_cap  = me;
                    m_free = me + 10;
                    sq_edge.push_back(me + 10);
                    sq_val.push_back(exp_pend(int'(sample), int'(volume1), int'(volume0)));
                end else begin
                    m_pending = 128;
                end
            end
            if (sq_edge.size() > 0 && sq_edge[0] == me) begin
                m_pending = sq_val[0];
                void'(sq_edge.pop_front());
                void'(sq_val.pop_front());
            end
            m_k = me;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (edge %0d, t=%0t)", name, act, exp, m_k, $time);
        end
    endtask

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clk) begin
        check("sample_req", int'(sample_req),
              int'(reset === 1'b1 && play && (m_k % D == D - 1) && (m_k >= m_free)));
        check("busy", int'(busy), int'(m_k >= m_cap && m_k <= m_cap + 8));
        check("pwm_out", int'(pwm_out), int'(m_pwm));
    end

    task automatic set_in(input logic p, input logic [7:0] s, input logic [3:0] a, input logic [3:0] b);
        #2;
        play = p; sample = s; volume1 = a; volume0 = b;
    endtask

    // Counts pwm_out highs and sample_req pulses over one aligned PWM period;
    // optionally swaps the sample chg_at cycles into the period.
    task automatic measure(input int chg_at, input logic [7:0] chg_s, output int highs, output int reqs);
        int guard;
        guard = 0;
        while (m_k % 256 != 1 && guard < 600) begin
            @(negedge clk);
            guard++;
        end
        check("measure_align", int'(guard < 600), 1);
        highs = 0;
        reqs  = 0;
        for (int i = 0; i < 256; i++) begin
            highs += int'(pwm_out);
            reqs  += int'(sample_req);
            if (i == chg_at) begin
                #2;
                sample = chg_s;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_case(input string name, input logic p, input logic [7:0] s,
                            input logic [3:0] a, input logic [3:0] b, input int exp_highs);
        int h, r;
        set_in(p, s, a, b);
        measure(-1, 8'h00, h, r);
        measure(-1, 8'h00, h, r);
        check(name, h, exp_highs);
    endtask

    initial begin
        int h, r, n, nb;
        reset = 1'b0; play = 1'b0; sample = 8'h80; volume1 = 4'd0; volume0 = 4'd0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;

        // Paused: no requests, silence duty in every period.
        for (int p = 0; p < 3; p++) begin
            measure(-1, 8'h00, h, r);
            check("paused_highs", h, 128);
            check("paused_reqs", r, 0);
        end

        // Full scale at unity gain, one request per 16 cycles.
        set_in(1'b1, 8'hFF, 4'd9, 4'd9);
        measure(-1, 8'h00, h, r);
        measure(-1, 8'h00, h, r);
        check("vol99_ff_highs", h, 255);
        check("vol99_reqs", r, 16);

        run_case("vol50_ff", 1'b1, 8'hFF, 4'd5, 4'd0, 192);
        run_case("vol50_00", 1'b1, 8'h00, 4'd5, 4'd0, 63);
        run_case("vol50_80", 1'b1, 8'h80, 4'd5, 4'd0, 128);
        run_case("mute_ff",  1'b1, 8'hFF, 4'd0, 4'd0, 128);
        run_case("nonbcd_00", 1'b1, 8'h00, 4'hC, 4'hF, 0);

        // Pending changes mid-period: duty holds until the wrap.
        set_in(1'b1, 8'hFF, 4'd9, 4'd9);
        measure(-1, 8'h00, h, r);
        measure(90, 8'h00, h, r);
        check("midperiod_hold", h, 255);
        measure(-1, 8'h00, h, r);
        check("after_wrap", h, 0);

        // Volume drop and pause during an op: result keeps captured volume, next tick forces silence.
        set_in(1'b1, 8'hFF, 4'd9, 4'd9);
        n = 0;
        while (m_k % 256 != 239 && n < 600) begin
            @(negedge clk);
            n++;
        end
        check("align_239", int'(n < 600), 1);
        @(negedge clk);
        set_in(1'b0, 8'h80, 4'd0, 4'd0);
        measure(-1, 8'h00, h, r);
        check("op_completes", h, 255);
        measure(-1, 8'h00, h, r);
        check("pause_forces_silence", h, 128);

        // Reset during MUL.
        set_in(1'b1, 8'hFF, 4'd9, 4'd9);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sample_req && n < 100);
        check("req_before_reset", int'(sample_req), 1);
        repeat (4) @(negedge clk);
        check("in_mul_busy", int'(busy), 1);
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_pwm", int'(pwm_out), 0);
        check("reset_busy", int'(busy), 0);
        #2 reset = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sample_req && n < 100);
        check("first_req_after_reset", n, 15);
        nb = 0;
        @(negedge clk);
        while (busy && nb < 50) begin
            nb++;
            @(negedge clk);
        end
        check("busy_width", nb, 9);
        measure(-1, 8'h00, h, r);
        check("post_reset_highs", h, 255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
